// File: rtl/inst_queue_if.sv
// Decoder-to-scoreboard instruction queue bus: multi-lane enqueue, multi-lane
// in-order dequeue, branch flush and status.
interface inst_queue_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned PUSH_W = 2,
    parameter int unsigned POP_W  = 2
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                     flush;
    logic [PUSH_W-1:0]        in_valid;
    logic [PUSH_W*DATA_W-1:0] in_bus;
    logic                     in_ready;
    logic [POP_W-1:0]         out_valid;
    logic [POP_W*DATA_W-1:0]  out_bus;
    logic [POP_W-1:0]         out_ready;
    logic [CNT_W-1:0]         count;
    logic                     empty;
    logic                     proto_err;

    // Producer/consumer side (decoder, scoreboard, branch unit)
    modport master (
        output flush, in_valid, in_bus, out_ready,
        input  in_ready, out_valid, out_bus, count, empty, proto_err
    );

    // Queue side
    modport slave (
        input  flush, in_valid, in_bus, out_ready,
        output in_ready, out_valid, out_bus, count, empty, proto_err
    );
endinterface

// File: rtl/inst_queue.sv
// Multi-lane circular instruction queue between decoder and scoreboard.
// Accepts up to PUSH_W bundles per cycle, presents the POP_W oldest bundles,
// and discards everything on a branch flush.
module inst_queue #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned PUSH_W = 2,
    parameter int unsigned POP_W  = 2
) (
    input  logic         clk,
    input  logic         reset,
    inst_queue_if.slave  q
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // Storage is deliberately left unreset; out_bus is gated by out_valid.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count_q;
    logic              in_ready_q;
    logic              empty_q;
    logic              proto_err_q;

    logic [PTR_W-1:0]  head_d;
    logic [PTR_W-1:0]  tail_d;
    logic [CNT_W-1:0]  count_d;
    logic              in_ready_d;

    logic              push_ok;
    logic [PUSH_W-1:0] wr_en;
    logic [PTR_W-1:0]  wr_addr [PUSH_W];
    logic [CNT_W-1:0]  push_n;

    logic [POP_W-1:0]  out_valid_c;
    logic [POP_W-1:0]  pop_lanes;
    logic [CNT_W-1:0]  pop_n;

    logic              in_not_prefix;
    logic              in_while_full;
    logic              out_not_prefix;
    logic              out_ghost;
    logic              err_c;

    // Enqueue: compact set lanes onto consecutive slots starting at tail
    always_comb begin
        push_ok = in_ready_q & ~q.flush;
        push_n  = '0;
        wr_en   = '0;
        for (int i = 0; i < int'(PUSH_W); i++) begin
            wr_addr[i] = tail + PTR_W'(push_n);
            wr_en[i]   = push_ok & q.in_valid[i];
            if (wr_en[i]) begin
                push_n = push_n + CNT_W'(1);
            end
        end
    end

    // Dequeue: lane j is valid while more than j entries are held
    always_comb begin
        pop_n = '0;
        for (int j = 0; j < int'(POP_W); j++) begin
            out_valid_c[j] = (count_q > CNT_W'(j));
        end
        pop_lanes = q.out_ready & out_valid_c;
        for (int j = 0; j < int'(POP_W); j++) begin
            if (pop_lanes[j]) begin
                pop_n = pop_n + CNT_W'(1);
            end
        end
    end

    // Next pointer/occupancy state; a flush wins over any push or pop
    always_comb begin
        head_d  = head + PTR_W'(pop_n);
        tail_d  = tail + PTR_W'(push_n);
        count_d = count_q + push_n - pop_n;
        if (q.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
        in_ready_d = (count_d <= CNT_W'(DEPTH - PUSH_W));
    end

    // Protocol checks: masks must be prefixes, no push while full, no pop of empty lanes
    always_comb begin
        in_not_prefix  = |(q.in_valid & (q.in_valid + PUSH_W'(1)));
        in_while_full  = (|q.in_valid) & ~in_ready_q;
        out_not_prefix = |(q.out_ready & (q.out_ready + POP_W'(1)));
        out_ghost      = |(q.out_ready & ~out_valid_c);
        err_c          = in_not_prefix | in_while_full | out_not_prefix | out_ghost;
    end

    // Pointer, occupancy and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            empty_q     <= 1'b1;
            proto_err_q <= 1'b0;
        end else begin
            head        <= head_d;
            tail        <= tail_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            empty_q     <= (count_d == '0);
            proto_err_q <= proto_err_q | err_c;
        end
    end

    // Entry storage write port (one slot per accepted lane)
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(PUSH_W); i++) begin
            if (wr_en[i]) begin
                mem[wr_addr[i]] <= q.in_bus[i*DATA_W +: DATA_W];
            end
        end
    end

    // Oldest-first read lanes, zero when the lane is not valid
    always_comb begin
        q.out_bus = '0;
        for (int j = 0; j < int'(POP_W); j++) begin
            if (out_valid_c[j]) begin
                q.out_bus[j*DATA_W +: DATA_W] = mem[head + PTR_W'(j)];
            end
        end
    end

    assign q.out_valid = out_valid_c;
    assign q.in_ready  = in_ready_q;
    assign q.count     = count_q;
    assign q.empty     = empty_q;
    assign q.proto_err = proto_err_q;

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: the driver updates a queue-based model and
// pushes the expected post-edge response; the monitor pops and compares.
module tb_inst_queue;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int PUSH_W = 2;
    localparam int POP_W  = 2;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [CNT_W-1:0]        count;
        logic                    in_ready;
        logic                    empty;
        logic                    err;
        logic [POP_W-1:0]        ov;
        logic [POP_W*DATA_W-1:0] ob;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    inst_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PUSH_W(PUSH_W), .POP_W(POP_W)) iq ();

    inst_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PUSH_W(PUSH_W), .POP_W(POP_W)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (iq)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mq [$];
    logic              m_err = 1'b0;
    exp_t              exp_q [$];
    int                n_tests = 0;
    int                n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit is_prefix(input logic [7:0] m, input int w);
        bit seen_zero = 0;
        for (int i = 0; i < w; i++) begin
            if (!m[i]) seen_zero = 1;
            else if (seen_zero) return 0;
        end
        return 1;
    endfunction

    // Apply inputs for the next edge and queue the response the model expects after it
    task automatic drive(input logic [PUSH_W-1:0] iv, input logic [PUSH_W*DATA_W-1:0] ib,
                         input logic [POP_W-1:0] orr, input logic fl);
        exp_t e;
        int   cnt;
        int   n;
        bit   rdy;
        bit   bad;
        @(negedge clk);
        iq.in_valid  = iv;
        iq.in_bus    = ib;
        iq.out_ready = orr;
        iq.flush     = fl;
        cnt = mq.size();
        rdy = (DEPTH - cnt) >= PUSH_W;
        bad = !is_prefix(8'(iv), PUSH_W) || (iv != 0 && !rdy) || !is_prefix(8'(orr), POP_W);
        n = 0;
        for (int j = 0; j < POP_W; j++) begin
            if (orr[j]) begin
                if (j < cnt) n++;
                else bad = 1;
            end
        end
        if (bad) m_err = 1'b1;
        if (fl) begin
            mq.delete();
        end else begin
            repeat (n) void'(mq.pop_front());
            if (rdy) begin
                for (int i = 0; i < PUSH_W; i++)
                    if (iv[i]) mq.push_back(ib[i*DATA_W +: DATA_W]);
            end
        end
        e.count    = CNT_W'(mq.size());
        e.in_ready = (DEPTH - mq.size()) >= PUSH_W;
        e.empty    = (mq.size() == 0);
        e.err      = m_err;
        e.ob       = '0;
        for (int j = 0; j < POP_W; j++) begin
            e.ov[j] = (mq.size() > j);
            if (mq.size() > j) e.ob[j*DATA_W +: DATA_W] = mq[j];
        end
        exp_q.push_back(e);
    endtask

    task automatic idle();
        drive('0, '0, '0, 1'b0);
    endtask

    // Reset asserted between edges; state must clear without a clock edge
    task automatic async_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        iq.in_valid  = '0;
        iq.in_bus    = '0;
        iq.out_ready = '0;
        iq.flush     = 1'b0;
        #1;
        chk("rst_count", 32'(iq.count), 0);
        chk("rst_in_ready", 32'(iq.in_ready), 1);
        chk("rst_empty", 32'(iq.empty), 1);
        chk("rst_out_valid", 32'(iq.out_valid), 0);
        chk("rst_out_bus", 32'(iq.out_bus), 0);
        chk("rst_proto_err", 32'(iq.proto_err), 0);
        mq.delete();
        m_err = 1'b0;
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [15:0] pair(input int a);
        return {8'(a + 1), 8'(a)};
    endfunction

    // Monitor: compare every DUT output against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("count", 32'(iq.count), 32'(e.count));
                chk("in_ready", 32'(iq.in_ready), 32'(e.in_ready));
                chk("empty", 32'(iq.empty), 32'(e.empty));
                chk("proto_err", 32'(iq.proto_err), 32'(e.err));
                chk("out_valid", 32'(iq.out_valid), 32'(e.ov));
                for (int j = 0; j < POP_W; j++)
                    chk($sformatf("out_bus[%0d]", j), 32'(iq.out_bus[j*DATA_W +: DATA_W]),
                        32'(e.ob[j*DATA_W +: DATA_W]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        int seq;
        int c;
        int np;
        int nq;
        logic [PUSH_W-1:0] iv;
        logic [POP_W-1:0]  orr;
        iq.in_valid  = '0;
        iq.in_bus    = '0;
        iq.out_ready = '0;
        iq.flush     = 1'b0;
        #1 reset = 1'b1;
        #2;
        chk("init_count", 32'(iq.count), 0);
        chk("init_in_ready", 32'(iq.in_ready), 1);
        chk("init_empty", 32'(iq.empty), 1);
        chk("init_out_valid", 32'(iq.out_valid), 0);
        chk("init_out_bus", 32'(iq.out_bus), 0);
        chk("init_proto_err", 32'(iq.proto_err), 0);
        #9 reset = 1'b0;

        // Two-lane push then presentation one cycle later
        drive(2'b11, {8'h22, 8'h11}, 2'b00, 1'b0);
        idle();
        // Fill to full
        seq = 16'h30;
        repeat (3) begin drive(2'b11, pair(seq), 2'b00, 1'b0); seq += 2; end
        idle();
        // Drain to 3
        drive('0, '0, 2'b11, 1'b0);
        drive('0, '0, 2'b11, 1'b0);
        drive('0, '0, 2'b01, 1'b0);
        // Steady push2/pop2 across the pointer wrap
        repeat (10) begin drive(2'b11, pair(seq), 2'b11, 1'b0); seq += 2; end
        // Grow to 5 then flush with push and pop requested
        drive(2'b11, pair(seq), 2'b00, 1'b0);
        seq += 2;
        drive(2'b11, pair(seq), 2'b11, 1'b1);
        idle();

        // Randomized legal traffic with occasional flushes
        for (int k = 0; k < 400; k++) begin
            c  = mq.size();
            np = ((DEPTH - c) >= PUSH_W) ? int'($urandom_range(PUSH_W, 0)) : 0;
            nq = int'($urandom_range(POP_W, 0));
            if (nq > c) nq = c;
            if ($urandom_range(3, 0) == 0) nq = 0;
            iv  = PUSH_W'((1 << np) - 1);
            orr = POP_W'((1 << nq) - 1);
            drive(iv, (PUSH_W*DATA_W)'($urandom()), orr, ($urandom_range(24, 0) == 0));
        end
        idle();

        // Push while full is dropped and flagged; reset mid-stream clears it
        async_reset();
        repeat (4) begin drive(2'b11, pair(seq), 2'b00, 1'b0); seq += 2; end
        drive(2'b01, 16'h00ee, 2'b00, 1'b0);
        idle();
        async_reset();
        // Pop request beyond the valid lanes
        drive(2'b01, 16'h0077, 2'b00, 1'b0);
        drive('0, '0, 2'b11, 1'b0);
        idle();
        async_reset();
        // Non-prefix out_ready
        drive(2'b11, {8'h66, 8'h55}, 2'b00, 1'b0);
        drive('0, '0, 2'b10, 1'b0);
        idle();
        async_reset();
        // Non-prefix in_valid: set lane still lands at tail
        drive(2'b10, {8'h99, 8'h88}, 2'b00, 1'b0);
        idle();
        async_reset();
        idle();
        idle();

        @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
